// File: rtl/pipe_pkg.sv
// pipe_pkg: shared definitions for the handshake pipeline stages and sinks.
package pipe_pkg;

   localparam int DATA_W    = 3;
   localparam int DEPTH_DEF = 4;

   typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a single control bit, async active-low reset.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_r;
   logic sync_r;

   // Capture the asynchronous bit, then re-time it once more before use
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/pipe_sink.sv
// pipe_sink: receives tokens over a two-phase req/ack link and buffers them
// in a small FIFO drained through a ready/valid interface.
// Optional feature macro: PIPE_SINK_CNT_EN adds a 16-bit token_cnt output
// counting FIFO writes.
module pipe_sink
   import pipe_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DATA_W-1:0]      data_in,
   input  logic                   req_in,
   output logic                   ack_out,
   output logic [DATA_W-1:0]      data_out,
   output logic                   valid_out,
   input  logic                   ready_in,
   output logic [$clog2(DEPTH):0] level
`ifdef PIPE_SINK_CNT_EN
   ,
   output logic [15:0]            token_cnt
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
   localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic             req_s;
   logic             ack_r;
   logic             pending_s;
   logic             wr_en_s;
   logic             rd_en_s;
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W-1:0] rd_ptr_nxt_s;
   logic [LVL_W-1:0] level_r;
   logic [LVL_W-1:0] level_nxt_s;
   logic             valid_r;
   data_t            mem_r [DEPTH];
   data_t            head_r;
   data_t            head_nxt_s;

   // Only the request line crosses domains; data_in is bundled and held
   // stable by the upstream stage until it sees ack_out move.
   sync2 u_req_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (req_in),
      .q     (req_s)
   );

   // Handshake decode, FIFO enables and next-state of level and head data
   always_comb begin
      level_nxt_s  = level_r;
      head_nxt_s   = head_r;
      pending_s    = (req_s != ack_r);
      // Write decision uses the pre-edge level, so a pop on a full FIFO
      // frees the slot for the following edge only.
      wr_en_s      = pending_s && (level_r < LVL_FULL);
      rd_en_s      = (level_r != LVL_ZERO) && ready_in;
      rd_ptr_nxt_s = rd_en_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      case ({wr_en_s, rd_en_s})
         2'b10:   level_nxt_s = level_r + LVL_ONE;
         2'b01:   level_nxt_s = level_r - LVL_ONE;
         default: level_nxt_s = level_r;
      endcase
      // The slot being written becomes the head when the FIFO is (or is
      // about to be) empty; otherwise the head comes from storage.
      if (wr_en_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
         head_nxt_s = data_in;
      end else begin
         head_nxt_s = mem_r[rd_ptr_nxt_s];
      end
   end

   // Toggle the acknowledge once per accepted token
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_r <= 1'b0;
      end else if (wr_en_s) begin
         ack_r <= ~ack_r;
      end else begin
         ack_r <= ack_r;
      end
   end

   // Advance read/write pointers; power-of-two depth wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         rd_ptr_r <= rd_ptr_nxt_s;
      end
   end

   // Track occupancy and the registered valid flag together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_r <= LVL_ZERO;
         valid_r <= 1'b0;
      end else begin
         level_r <= level_nxt_s;
         valid_r <= (level_nxt_s != LVL_ZERO);
      end
   end

   // FIFO storage, cleared on reset so the head reads as zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_W{1'b0}};
         end
      end else if (wr_en_s) begin
         mem_r[wr_ptr_r] <= data_in;
      end
   end

   // Registered copy of the head entry drives data_out
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_r <= {DATA_W{1'b0}};
      end else begin
         head_r <= head_nxt_s;
      end
   end

`ifdef PIPE_SINK_CNT_EN
   logic [15:0] token_cnt_r;

   // Count every FIFO write, wrapping at 16 bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         token_cnt_r <= 16'h0000;
      end else if (wr_en_s) begin
         token_cnt_r <= token_cnt_r + 16'h0001;
      end else begin
         token_cnt_r <= token_cnt_r;
      end
   end

   assign token_cnt = token_cnt_r;
`endif

   assign ack_out   = ack_r;
   assign data_out  = head_r;
   assign valid_out = valid_r;
   assign level     = level_r;

endmodule

// File: tb/tb_pipe_sink.sv
// tb_pipe_sink: self-checking bench for pipe_sink with a queue-based model.
module tb_pipe_sink;
   import pipe_pkg::*;

   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   typedef struct {
      logic [DATA_W-1:0] din;
      logic [DATA_W-1:0] exp_dout;
      int                exp_level;
   } vec_t;

   logic              clk      = 1'b0;
   logic              rst_n    = 1'b1;
   logic [DATA_W-1:0] data_in  = 3'b000;
   logic              req_in   = 1'b0;
   logic              ack_out;
   logic [DATA_W-1:0] data_out;
   logic              valid_out;
   logic              ready_in = 1'b0;
   logic [LW-1:0]     level;
`ifdef PIPE_SINK_CNT_EN
   logic [15:0]       token_cnt;
`endif

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] model_q  [$];
   logic [DATA_W-1:0] popped_q [$];
   logic              prev_ack   = 1'b0;
   bit                prev_pop   = 1'b0;
   bit                mon_en     = 1'b0;
   bit                rand_ready = 1'b0;
   int                pushes     = 0;

   always #5 clk = ~clk;

   pipe_sink #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_in   (data_in),
      .req_in    (req_in),
      .ack_out   (ack_out),
      .data_out  (data_out),
      .valid_out (valid_out),
      .ready_in  (ready_in),
      .level     (level)
`ifdef PIPE_SINK_CNT_EN
      ,
      .token_cnt (token_cnt)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic chk_seq(input string name, input logic [DATA_W-1:0] exp[$]);
      chk({name, "_len"}, popped_q.size(), exp.size());
      for (int i = 0; i < exp.size() && i < popped_q.size(); i++) begin
         chk(name, popped_q[i], exp[i]);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_ack(input int budget);
      int n = 0;
      while (ack_out !== req_in && n < budget) begin
         cyc(1);
         n++;
      end
      if (ack_out !== req_in) begin
         chk("ack_timeout", ack_out, req_in);
      end
   endtask

   // Upstream stage: hold data until the previous token is acknowledged
   task automatic send(input logic [DATA_W-1:0] d);
      wait_ack(300);
      cyc(1);
      data_in = d;
      req_in  = ~req_in;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      ready_in = 1'b1;
      while ((level != 0 || ack_out !== req_in) && n < budget) begin
         cyc(1);
         n++;
      end
      chk("drain_empty", level, 0);
      cyc(2);
      ready_in = 1'b0;
   endtask

   // Reference model: a token enters on each ack toggle, leaves on each
   // accepted pop; outputs must always reflect the queue.
   always @(negedge clk) begin
      if (!mon_en || !rst_n) begin
         model_q.delete();
         prev_ack = ack_out;
         prev_pop = 1'b0;
         pushes   = 0;
      end else begin
         if (prev_pop) popped_q.push_back(model_q.pop_front());
         if (ack_out !== prev_ack) begin
            chk("space_on_write", model_q.size() < DEPTH, 1);
            model_q.push_back(data_in);
            pushes++;
         end
         prev_ack = ack_out;
         chk("mon_level", level, model_q.size());
         chk("mon_valid", valid_out, model_q.size() != 0);
         if (model_q.size() != 0) chk("mon_data", data_out, model_q[0]);
         prev_pop = (model_q.size() != 0) && (ready_in === 1'b1);
      end
   end

   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         ready_in = ($urandom_range(0, 1) == 1);
      end
   end

   initial begin
      vec_t vec [4];
      logic a0;
      logic a1;
      int   p0;

      vec[0] = '{din: 3'b101, exp_dout: 3'b101, exp_level: 1};
      vec[1] = '{din: 3'b010, exp_dout: 3'b101, exp_level: 2};
      vec[2] = '{din: 3'b111, exp_dout: 3'b101, exp_level: 3};
      vec[3] = '{din: 3'b000, exp_dout: 3'b101, exp_level: 4};

      // Reset state
      #1 rst_n = 1'b0;
      #2;
      chk("rst_ack", ack_out, 0);
      chk("rst_valid", valid_out, 0);
      chk("rst_level", level, 0);
      chk("rst_data", data_out, 0);
`ifdef PIPE_SINK_CNT_EN
      chk("rst_cnt", token_cnt, 0);
`endif
      cyc(1);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      cyc(2);

      // Table: latency of each token and accumulation with ready_in low
      ready_in = 1'b0;
      foreach (vec[i]) begin
         a0 = ack_out;
         send(vec[i].din);
         cyc(2);
         chk("lat_early_ack", ack_out, a0);
         cyc(1);
         a1 = ~a0;
         chk("lat_ack", ack_out, a1);
         chk("lat_valid", valid_out, 1);
         chk("lat_data", data_out, vec[i].exp_dout);
         chk("lat_level", level, vec[i].exp_level);
      end
      popped_q.delete();
      drain(40);
      chk_seq("tbl_order", {3'd5, 3'd2, 3'd7, 3'd0});

      // Full: 4 accepted, 5th held back until a slot frees
      p0 = pushes;
      a0 = ack_out;
      for (int k = 1; k <= 5; k++) send(3'(k));
      cyc(8);
      chk("full_level", level, 4);
      chk("full_toggles", pushes - p0, 4);
      chk("full_pending", ack_out != req_in, 1);
      chk("full_ack_parity", ack_out, a0);
      popped_q.delete();
      ready_in = 1'b1;
      cyc(1);
      ready_in = 1'b0;
      chk("fullpop_level", level, 3);
      chk("fullpop_ack_hold", ack_out, a0);
      cyc(1);
      a1 = ~a0;
      chk("fullpop_write_next", level, 4);
      chk("fullpop_ack_toggled", ack_out, a1);
      drain(60);
      chk_seq("full_order", {3'd1, 3'd2, 3'd3, 3'd4, 3'd5});

      // Simultaneous write and pop at level 2
      send(3'd6);
      send(3'd3);
      wait_ack(20);
      cyc(1);
      chk("sim_pre_level", level, 2);
      a0 = ack_out;
      popped_q.delete();
      send(3'd4);
      cyc(2);
      ready_in = 1'b1;
      cyc(1);
      ready_in = 1'b0;
      a1 = ~a0;
      chk("sim_level", level, 2);
      chk("sim_ack", ack_out, a1);
      chk("sim_head", data_out, 3'd3);
      drain(40);
      chk_seq("sim_order", {3'd6, 3'd3, 3'd4});

      // Pointer wrap with the consumer always ready
      popped_q.delete();
      ready_in = 1'b1;
      for (int k = 0; k < 10; k++) send(3'(k % 8));
      drain(60);
      chk_seq("wrap_order", {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1});

      // Random data, gaps and consumer back-pressure
      p0 = pushes;
      rand_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         send(3'($urandom_range(0, 7)));
         cyc($urandom_range(0, 3));
      end
      rand_ready = 1'b0;
      cyc(2);
      drain(300);
      chk("rand_count", pushes - p0, 40);

      // Reset mid-transfer: outputs clear without a clock edge
      ready_in = 1'b0;
      send(3'd1);
      send(3'd2);
      wait_ack(20);
      send(3'd3);
      cyc(1);
      @(posedge clk);
      #2;
      rst_n   = 1'b0;
      req_in  = 1'b0;
      data_in = 3'b000;
      #1;
      chk("rstmid_ack", ack_out, 0);
      chk("rstmid_valid", valid_out, 0);
      chk("rstmid_level", level, 0);
`ifdef PIPE_SINK_CNT_EN
      chk("rstmid_cnt", token_cnt, 0);
`endif
      cyc(1);
      rst_n = 1'b1;
      cyc(2);

      // Clean operation after reset
      send(3'd5);
      cyc(3);
      chk("post_rst_ack", ack_out, 1);
      chk("post_rst_data", data_out, 3'd5);
      chk("post_rst_level", level, 1);
      drain(20);
`ifdef PIPE_SINK_CNT_EN
      chk("token_cnt", token_cnt, pushes & 32'h0000FFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
